pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, fully pipelined two's-complement adder/subtractor with valid/ready flow control. Carry propagation is split across `STAGES` register slices so `W` can grow without lengthening the critical path. It provides unsigned carry/no-borrow, signed overflow and zero flags. It is the next-generation datapath adder for the arithmetic units and replaces the fixed-width, always-flowing single-stage adder.

## Interface
- `W`, 64: operand and result width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: number of carry slices / pipeline stages, range 1..`W`; slice width `SW` = `W`/`STAGES`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present on `a`, `b`, `operation`.
- `in_ready`  out  1  block accepts the operand set this cycle.
- `a`  in  `W`  operand A.
- `b`  in  `W`  operand B.
- `operation`  in  1  0 = A+B, 1 = A−B.
- `out_valid`  out  1  result outputs are valid.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `sum`  out  `W`  result.
- `carry`  out  1  carry-out; for subtract, 1 = no borrow (A ≥ B unsigned).
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `sum` == 0.

## Operation
- Subtract is computed as A + ~B + 1: B is inverted and the carry-in of slice 0 is 1. Carry-in is 0 for add. The separate two's-complement negation of B is not used, so `carry` is exact for B = 0.
- Stage k (0..`STAGES`−1) adds bits [k·`SW` +: `SW`] of A and B' together with the carry registered by stage k−1.
- Its registered outputs are:
  - its sum slice;
  - its carry-out;
  - the not-yet-used upper operand slices, skewed forward;
  - the already-finished lower sum slices.
- The last stage registers `sum`, `carry`, `overflow` and `zero`.
- `overflow` = carry into the MSB XOR carry out of the MSB, computed inside the last slice.
- `zero` is the NOR of the full `W`-bit result, computed in the last stage.
- Each stage holds a valid bit v[k]. Input transfer happens when `in_valid` && `in_ready`. Output transfer happens when `out_valid` && `out_ready`.
- Global stall rule: advance = !`out_valid` || `out_ready`.
  - On advance, every stage loads from its predecessor. Stage 0 loads the input and sets v[0] = `in_valid`.
  - Without advance, all stage registers and valids hold.
- `in_ready` = advance; it is combinational from `out_ready` and `out_valid` only, and never depends on `in_valid`.
- `out_valid` = v[`STAGES`−1]. Outputs stay stable while `out_valid` && !`out_ready`.
- Bubbles are not collapsed; the pipeline is strictly in-order, with no reordering or dropping.

## Timing
- Latency: an operand set accepted at edge n appears with `out_valid`=1 after edge n+`STAGES−1`. That is `STAGES` registers from `a`/`b` to `sum`.
- Throughput: one result per cycle while `out_ready`=1.
- Reset values, held while `rst`=1: all v[k]=0, `out_valid`=0, `sum`=0, `carry`=0, `overflow`=0, `zero`=0.
  - `in_ready` is 1 during and after reset, because `out_valid`=0.
  - Inputs presented during `rst`=1 are discarded.
- Reset mid-operation: all in-flight results are discarded at the reset edge. No result is emitted for them.
- Simultaneous output consume and input accept in the same cycle is legal and is the normal streaming case.
- Stall entry and exit: while `out_ready` is low with `out_valid` high, the pipeline freezes. `in_ready` falls in that same cycle and rises in the cycle `out_ready` returns.
- `STAGES`=1: single registered adder, latency 1 cycle.

## Structure
- Shared package `addsub_pkg`:
  - op encoding constants `OP_ADD`=1'b0, `OP_SUB`=1'b1;
  - the result flags struct (`carry`, `overflow`, `zero`).
- Sub-module `addsub_slice` (parameter `SW`): a combinational `SW`-bit ripple add with cin, producing sum, cout and the MSB carry-in.
- The top level instantiates `STAGES` slices in a generate loop and owns all registers and valid/stall logic.
- Elaboration-time check: `W` % `STAGES` == 0.

## Test plan
- Reset, `W`=64, `STAGES`=4: `rst`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, all outputs 0 and `in_ready`=1 throughout. First result appears only from post-reset input.
- Add across slices: A=0x0000_0000_FFFF_FFFF, B=1, `operation`=0 → `sum`=0x0000_0001_0000_0000, `carry`=0, `overflow`=0, `zero`=0, after exactly 4 cycles.
- Subtract edge cases:
  - A=5, B=5 → `sum`=0, `zero`=1, `carry`=1.
  - A=0, B=1 → `sum`=0xFFFF…FFFF, `carry`=0.
  - A=0x8000…0000, B=1 → `overflow`=1.
- Full-width carry: A=0xFFFF…FFFF, B=1 add → `sum`=0, `carry`=1, `zero`=1, `overflow`=0. Back-to-back stream of 16 random ops with `out_ready`=1 → 16 consecutive in-order results matching a reference model.
- Backpressure: while streaming, hold `out_ready`=0 for 3 cycles → `sum` and flags stable, `in_ready`=0, no loss or duplication after release. Repeat with `STAGES`=1 and `STAGES`=8, `W`=32.
- Reset mid-stream with 3 results in flight → no `out_valid` after reset until new input has traversed `STAGES` cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared op encoding and result flag layout for the pipelined adder/subtractor
// Contents:
//   OP_ADD / OP_SUB : encoding of the operation input
//   flags_t         : registered result flags (carry, overflow, zero)
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
   } flags_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for pipelined_addsub
// Signals:
//   in_valid, in_ready, a, b, operation        : operand side (master drives, slave accepts)
//   out_valid, out_ready, sum, carry,
//   overflow, zero                             : result side (slave drives, master consumes)
// Modports: master = producer/consumer around the block, slave = the block itself.
interface pipelined_addsub_if #(
   parameter int W = 64
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         operation;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;
   logic         zero;

   modport master (
      output in_valid, a, b, operation, out_ready,
      input  in_ready, out_valid, sum, carry, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, operation, out_ready,
      output in_ready, out_valid, sum, carry, overflow, zero
   );

endinterface

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SW-bit add slice with carry-in
// Ports:
//   a_i, b_i   : slice operands (b_i already inverted for subtract)
//   cin_i      : carry into the slice
//   sum_o      : slice sum
//   cout_o     : carry out of the slice MSB
//   msb_cin_o  : carry into the slice MSB (used for signed overflow)
module addsub_slice #(
   parameter int SW = 16
) (
   input  logic [SW-1:0] a_i,
   input  logic [SW-1:0] b_i,
   input  logic          cin_i,
   output logic [SW-1:0] sum_o,
   output logic          cout_o,
   output logic          msb_cin_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};

   // The MSB sum bit is a ^ b ^ cin, so the carry into it falls out directly.
   assign msb_cin_o = a_i[SW-1] ^ b_i[SW-1] ^ sum_o[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep pipelined W-bit adder/subtractor with valid/ready flow control
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipelined_addsub_if slave (operands in, result + carry/overflow/zero out)
// Parameters:
//   W      : operand/result width, multiple of STAGES
//   STAGES : number of carry slices and register stages (latency in cycles)
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int W      = 64,
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
   pipelined_addsub_if.slave bus
);

   localparam int SW = W / STAGES;

   if ((STAGES < 1) || (STAGES > W) || ((W % STAGES) != 0)) begin : g_param_check
      $error("pipelined_addsub: W must be a positive multiple of STAGES");
   end

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic              advance;
   logic [W-1:0]      b_eff;
   logic              cin0;
   logic [W-1:0]      res_q;
   flags_t            flags_q;

   // Single global stall: the whole pipe moves only when the output slot is free or drained.
   assign advance = !v_q[STAGES-1] || bus.out_ready;

   // Subtract as A + ~B + 1 so carry stays exact for B = 0.
   assign b_eff = (bus.operation == OP_ADD) ? bus.b : ~bus.b;
   assign cin0  = (bus.operation == OP_SUB);

   always_comb begin
      v_d = v_q;
      if (advance) begin
         v_d[0] = bus.in_valid;
         for (int k = 1; k < STAGES; k++) begin
            v_d[k] = v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         v_q <= v_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SW;
      localparam int HI = LO + SW;

      // Operand bits from this slice upward; lower slices are already consumed.
      logic [W-LO-1:0] op_a;
      logic [W-LO-1:0] op_b;
      logic            s_cin;
      logic [SW-1:0]   s_sum;
      logic            s_cout;
      logic            s_msb_cin;
      // Finished result bits [HI-1:0] once this slice has added.
      logic [HI-1:0]   sum_d;

      if (k == 0) begin : g_src
         assign op_a  = bus.a;
         assign op_b  = b_eff;
         assign s_cin = cin0;
         assign sum_d = s_sum;
      end else begin : g_src
         assign op_a  = g_stage[k-1].g_reg.a_q;
         assign op_b  = g_stage[k-1].g_reg.b_q;
         assign s_cin = g_stage[k-1].g_reg.c_q;
         assign sum_d = {s_sum, g_stage[k-1].g_reg.sum_q};
      end

      addsub_slice #(
         .SW (SW)
      ) u_slice (
         .a_i       (op_a[SW-1:0]),
         .b_i       (op_b[SW-1:0]),
         .cin_i     (s_cin),
         .sum_o     (s_sum),
         .cout_o    (s_cout),
         .msb_cin_o (s_msb_cin)
      );

      if (k < STAGES - 1) begin : g_reg
         logic [W-HI-1:0] a_q;
         logic [W-HI-1:0] b_q;
         logic            c_q;
         logic [HI-1:0]   sum_q;

         // Datapath registers need no reset: the valid bits qualify them.
         always_ff @(posedge clk) begin
            if (advance) begin
               a_q   <= op_a[W-LO-1:SW];
               b_q   <= op_b[W-LO-1:SW];
               c_q   <= s_cout;
               sum_q <= sum_d;
            end
         end
      end else begin : g_out
         always_ff @(posedge clk) begin
            if (rst) begin
               res_q   <= '0;
               flags_q <= '0;
            end else if (advance) begin
               res_q            <= sum_d;
               flags_q.carry    <= s_cout;
               flags_q.overflow <= s_cout ^ s_msb_cin;
               flags_q.zero     <= ~|sum_d;
            end
         end
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = res_q;
   assign bus.carry     = flags_q.carry;
   assign bus.overflow  = flags_q.overflow;
   assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub (W64/S4, W64/S1, W32/S8)
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_q = 1'b0;
   logic        in_valid;
   logic [63:0] a;
   logic [63:0] b;
   logic        op;
   logic        out_ready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [66:0] sbq [3][$];
   bit          prev_stall [3];
   logic [66:0] prev_obs [3];

   always #5 clk = ~clk;

   pipelined_addsub_if #(.W(64)) bus0 ();
   pipelined_addsub_if #(.W(64)) bus1 ();
   pipelined_addsub_if #(.W(32)) bus2 ();

   assign bus0.in_valid  = in_valid;
   assign bus0.a         = a;
   assign bus0.b         = b;
   assign bus0.operation = op;
   assign bus0.out_ready = out_ready;
   assign bus1.in_valid  = in_valid;
   assign bus1.a         = a;
   assign bus1.b         = b;
   assign bus1.operation = op;
   assign bus1.out_ready = out_ready;
   assign bus2.in_valid  = in_valid;
   assign bus2.a         = a[31:0];
   assign bus2.b         = b[31:0];
   assign bus2.operation = op;
   assign bus2.out_ready = out_ready;

   pipelined_addsub #(.W(64), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   pipelined_addsub #(.W(64), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   pipelined_addsub #(.W(32), .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always @(posedge clk) rst_q <= rst;

   task automatic check_eq(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: {sum[63:0], carry, overflow, zero}, sign rule for overflow.
   function automatic logic [66:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                         input logic mop, input int w);
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bm;
      logic [64:0] full;
      logic [63:0] s;
      logic        c;
      logic        o;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      am   = ma & mask;
      bm   = (mop ? ~mb : mb) & mask;
      full = {1'b0, am} + {1'b0, bm} + {64'd0, mop};
      s    = full[63:0] & mask;
      c    = full[w];
      o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {s, c, o, (s == 64'd0)};
   endfunction

   task automatic observe(input int id, input logic ov, input logic ir, input logic [63:0] s,
                          input logic c, input logic o, input logic z, input int w);
      logic [66:0] obs;
      logic [66:0] exp;
      obs = {s, c, o, z};
      if (rst_q) begin
         check_eq($sformatf("d%0d_rst_ov", id), {66'd0, ov}, 67'd0);
         check_eq($sformatf("d%0d_rst_ir", id), {66'd0, ir}, 67'd1);
         check_eq($sformatf("d%0d_rst_out", id), obs, 67'd0);
      end else if (prev_stall[id]) begin
         check_eq($sformatf("d%0d_hold", id), obs, prev_obs[id]);
      end
      if (ov && !out_ready) check_eq($sformatf("d%0d_ir_stall", id), {66'd0, ir}, 67'd0);
      if (out_ready)        check_eq($sformatf("d%0d_ir_free", id), {66'd0, ir}, 67'd1);
      prev_stall[id] = ov && !out_ready && !rst;
      prev_obs[id]   = obs;
      if (rst) begin
         sbq[id].delete();
      end else begin
         if (ov && out_ready) begin
            if (sbq[id].size() == 0) begin
               check_eq($sformatf("d%0d_spurious", id), 67'd1, 67'd0);
            end else begin
               exp = sbq[id].pop_front();
               check_eq($sformatf("d%0d_sum", id), {3'd0, obs[66:3]}, {3'd0, exp[66:3]});
               check_eq($sformatf("d%0d_flags", id), {64'd0, obs[2:0]}, {64'd0, exp[2:0]});
            end
         end
         if (in_valid && ir) sbq[id].push_back(model(a, b, op, w));
      end
   endtask

   always @(negedge clk) begin
      observe(0, bus0.out_valid, bus0.in_ready, bus0.sum, bus0.carry, bus0.overflow, bus0.zero, 64);
      observe(1, bus1.out_valid, bus1.in_ready, bus1.sum, bus1.carry, bus1.overflow, bus1.zero, 64);
      observe(2, bus2.out_valid, bus2.in_ready, {32'd0, bus2.sum}, bus2.carry, bus2.overflow,
              bus2.zero, 32);
   end

   // One isolated operation: exact latency on all three, constant result on the W=64 ones.
   task automatic run_solo(input logic [63:0] ta, input logic [63:0] tbv, input logic top,
                           input logic [63:0] esum, input logic [2:0] eflg);
      int lat0 = -1;
      int lat1 = -1;
      int lat2 = -1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = ta;
      b = tbv;
      op = top;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus0.out_valid && lat0 < 0) begin
            lat0 = cyc;
            check_eq("solo_sum_s4", {3'd0, bus0.sum}, {3'd0, esum});
            check_eq("solo_flg_s4", {64'd0, bus0.carry, bus0.overflow, bus0.zero}, {64'd0, eflg});
         end
         if (bus1.out_valid && lat1 < 0) begin
            lat1 = cyc;
            check_eq("solo_sum_s1", {3'd0, bus1.sum}, {3'd0, esum});
            check_eq("solo_flg_s1", {64'd0, bus1.carry, bus1.overflow, bus1.zero}, {64'd0, eflg});
         end
         if (bus2.out_valid && lat2 < 0) lat2 = cyc;
         if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0) break;
         @(posedge clk);
      end
      check_eq("lat_s4", 67'(lat0), 67'd3);
      check_eq("lat_s1", 67'(lat1), 67'd0);
      check_eq("lat_s8", 67'(lat2), 67'd7);
   endtask

   task automatic drive_rand(input logic valid);
      in_valid = valid;
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      op = 1'($urandom_range(1));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 64'd7;
      b         = 64'd3;
      op        = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_eq("post_rst_idle", {66'd0, bus0.out_valid}, 67'd0);
      end

      run_solo(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 3'b000);
      run_solo(64'd5, 64'd5, 1'b1, 64'd0, 3'b101);
      run_solo(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000);
      run_solo(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110);
      run_solo(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 3'b101);
      run_solo(64'h1234, 64'd0, 1'b1, 64'h1234, 3'b100);
      run_solo(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 3'b010);

      // Back-to-back random stream, always consuming.
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         drive_rand(1'b1);
      end

      // Continuous stream with a 3-cycle output stall once every pipe is full.
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         drive_rand(1'b1);
         out_ready = !(i >= 10 && i < 13);
      end

      // Random valid/ready mix.
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         drive_rand($urandom_range(3) != 0);
         out_ready = 1'($urandom_range(1));
      end

      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);

      // Three operations in flight on the 4-stage pipe, then reset.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         drive_rand(1'b1);
      end
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_eq("mid_rst_idle", {66'd0, bus0.out_valid}, 67'd0);
      end
      run_solo(64'd100, 64'd58, 1'b1, 64'd42, 3'b100);

      // Drain and confirm nothing is left outstanding.
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      end
      check_eq("drain_s4", 67'(sbq[0].size()), 67'd0);
      check_eq("drain_s1", 67'(sbq[1].size()), 67'd0);
      check_eq("drain_s8", 67'(sbq[2].size()), 67'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
